// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry and timing constants plus the motion FSM state type
package vga_pkg;
  localparam int H_ACTIVE_C = 640;
  localparam int V_ACTIVE_C = 480;
  localparam int H_SYNC_START_C = 656;
  localparam int H_SYNC_END_C = 752;
  localparam int H_TOTAL_C = 800;
  localparam int V_SYNC_START_C = 490;
  localparam int V_SYNC_END_C = 492;
  localparam int V_TOTAL_C = 525;
  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, COMMIT} motion_state_t;
endpackage

// File: rtl/axis_bounce.sv
// axis_bounce: one-axis step with clamp-and-reflect at [radius, limit], 11-bit arithmetic
module axis_bounce (
  input  logic [9:0]  pos,
  input  logic        dir,
  input  logic [2:0]  spd,
  input  logic [10:0] limit,
  input  logic [10:0] radius,
  output logic [9:0]  next_pos,
  output logic        next_dir,
  output logic        bounced
);
  logic [10:0] sum;
  logic [10:0] low;
  // dir=1 moves toward limit; reaching or crossing a wall clamps onto it and reflects
  always_comb begin
    sum = {1'b0, pos} + {8'd0, spd};
    low = radius + {8'd0, spd};
    bounced = dir ? (sum >= limit) : ({1'b0, pos} < low);
    next_pos = bounced ? (dir ? limit[9:0] : radius[9:0]) : (dir ? sum[9:0] : pos - {7'd0, spd});
    next_dir = dir ^ bounced;
  end
endmodule

// File: rtl/circle_motion_ctrl.sv
// circle_motion_ctrl: vsync-paced circle centre mover with wall bounce; CIRCLE_COLOR_CYCLE_EN enables bounce colour cycling
module circle_motion_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_C,
  parameter int V_ACTIVE  = V_ACTIVE_C,
  parameter int RADIUS    = 20,
  parameter int INIT_X    = 320,
  parameter int INIT_Y    = 240,
  parameter int FRAME_DIV = 1
) (
  input  logic       VGA_CLK,
  input  logic       Reset,
  input  logic       VGA_VS,
  input  logic [2:0] Speed,
  input  logic       Pause,
  input  logic       Step_Req,
  output logic [9:0] Center_X,
  output logic [9:0] Center_Y,
  output logic       Busy,
  output logic       Update_Done,
  output logic [1:0] Color_Sel
);
  localparam logic [10:0] X_HI = 11'(H_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] Y_HI = 11'(V_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] RAD = 11'(RADIUS);
  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
  motion_state_t state;
  logic vs_d;
  logic [3:0] frame_cnt;
  logic step_armed;
  logic [2:0] spd;
  logic [9:0] nx, ny, px, py;
  logic dx, dy, pdx, pdy, bx, by;
  logic tick, due, start;
  assign tick = vs_d & ~VGA_VS;
  assign due = frame_cnt == DIV_LAST;
  assign start = tick & due & (state == IDLE) & (~Pause | step_armed);
  axis_bounce ax (.pos(nx), .dir(dx), .spd(spd), .limit(X_HI), .radius(RAD), .next_pos(px), .next_dir(pdx), .bounced(bx));
  axis_bounce ay (.pos(ny), .dir(dy), .spd(spd), .limit(Y_HI), .radius(RAD), .next_pos(py), .next_dir(pdy), .bounced(by));
  // frame divider, step arming and the three-cycle update sequence; outputs only move at COMMIT
  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      state <= IDLE;
      vs_d <= 1'b1;
      frame_cnt <= '0;
      step_armed <= 1'b0;
      spd <= '0;
      nx <= 10'(INIT_X);
      ny <= 10'(INIT_Y);
      dx <= 1'b1;
      dy <= 1'b1;
      Center_X <= 10'(INIT_X);
      Center_Y <= 10'(INIT_Y);
      Busy <= 1'b0;
      Update_Done <= 1'b0;
    end else begin
      vs_d <= VGA_VS;
      if (tick) frame_cnt <= due ? '0 : frame_cnt + 4'd1;
      if (start) step_armed <= 1'b0;
      else if (Step_Req & Pause) step_armed <= 1'b1;
      Update_Done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= MOVE_X;
          spd <= Speed;
          Busy <= 1'b1;
        end
        MOVE_X: begin
          nx <= px;
          dx <= pdx;
          state <= MOVE_Y;
        end
        MOVE_Y: begin
          ny <= py;
          dy <= pdy;
          state <= COMMIT;
        end
        COMMIT: begin
          Center_X <= nx;
          Center_Y <= ny;
          Update_Done <= 1'b1;
          Busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
`ifdef CIRCLE_COLOR_CYCLE_EN
  logic bnc;
  // a corner hit sets the flag twice but advances the colour once
  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      bnc <= 1'b0;
      Color_Sel <= '0;
    end else begin
      if (state == MOVE_X) bnc <= bx;
      else if (state == MOVE_Y) bnc <= bnc | by;
      if (state == COMMIT && bnc) Color_Sel <= Color_Sel + 2'd1;
    end
  end
`else
  logic unused_bnc;
  assign unused_bnc = bx ^ by;
  assign Color_Sel = '0;
`endif
endmodule

// File: tb/tb_circle_motion_ctrl.sv
// tb_circle_motion_ctrl: directed and randomized checks of circle_motion_ctrl against a frame-level reference model
module tb_circle_motion_ctrl;
  localparam int FD = 1;
  localparam int LO = 20;
  localparam int XHI = 640 - 1 - 20;
  localparam int YHI = 480 - 1 - 20;
`ifdef CIRCLE_COLOR_CYCLE_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs = 1'b1;
  logic [2:0] speed = '0;
  logic pause = 1'b0;
  logic step_req = 1'b0;
  logic [9:0] cx, cy, cx3, cy3;
  logic busy, ud, busy3, ud3;
  logic [1:0] col, col3;
  int tests = 0;
  int fails = 0;
  int ud_cnt = 0;
  int ud3_cnt = 0;
  int m_x, m_y, m_dx, m_dy, m_cx, m_cy, m_col, m_ph, m_fc;
  bit m_arm, m_vsd, m_b, m_ud;
  always #5 clk = ~clk;
  circle_motion_ctrl dut (
    .VGA_CLK(clk), .Reset(rst), .VGA_VS(vs), .Speed(speed), .Pause(pause), .Step_Req(step_req),
    .Center_X(cx), .Center_Y(cy), .Busy(busy), .Update_Done(ud), .Color_Sel(col)
  );
  circle_motion_ctrl #(.INIT_X(617), .INIT_Y(21), .FRAME_DIV(3)) dut3 (
    .VGA_CLK(clk), .Reset(rst), .VGA_VS(vs), .Speed(speed), .Pause(pause), .Step_Req(step_req),
    .Center_X(cx3), .Center_Y(cy3), .Busy(busy3), .Update_Done(ud3), .Color_Sel(col3)
  );
  task automatic chk(string tag, logic [31:0] obs, int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic mv(inout int p, inout int d, input int s, input int hi, inout bit b);
    if (d > 0) begin
      if (p + s >= hi) begin p = hi; d = -1; b = 1'b1; end
      else p = p + s;
    end else begin
      if (p < LO + s) begin p = LO; d = 1; b = 1'b1; end
      else p = p - s;
    end
  endtask
  task automatic mreset();
    m_x = 320; m_y = 240; m_cx = 320; m_cy = 240; m_dx = 1; m_dy = 1;
    m_col = 0; m_ph = 0; m_fc = 0; m_arm = 1'b0; m_vsd = 1'b1; m_b = 1'b0; m_ud = 1'b0;
  endtask
  // one clock: advance the model for the coming edge, then compare after it
  task automatic cyc();
    bit tk, st, commit;
    if (rst) mreset();
    else begin
      tk = m_vsd && !vs;
      commit = (m_ph == 1);
      st = tk && m_ph == 0 && m_fc == FD - 1 && (!pause || m_arm);
      if (tk) m_fc = (m_fc == FD - 1) ? 0 : m_fc + 1;
      if (st) m_arm = 1'b0;
      else if (step_req && pause) m_arm = 1'b1;
      m_vsd = vs;
      if (m_ph > 0) m_ph--;
      else if (st) begin
        m_ph = 3;
        m_b = 1'b0;
        mv(m_x, m_dx, int'(speed), XHI, m_b);
        mv(m_y, m_dy, int'(speed), YHI, m_b);
      end
      if (commit) begin
        m_cx = m_x;
        m_cy = m_y;
        if (m_b && CC) m_col = (m_col + 1) % 4;
      end
      m_ud = commit;
    end
    @(posedge clk);
    #1;
    ud_cnt += int'(ud);
    ud3_cnt += int'(ud3);
    chk("center_x", 32'(cx), m_cx);
    chk("center_y", 32'(cy), m_cy);
    chk("busy", 32'(busy), int'(m_ph > 0));
    chk("update_done", 32'(ud), int'(m_ud));
    chk("color_sel", 32'(col), m_col);
  endtask
  task automatic frame(int lo, int hi);
    vs = 1'b0;
    repeat (lo) cyc();
    vs = 1'b1;
    repeat (hi) cyc();
  endtask
  initial begin
    int u0;
    mreset();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_cx", 32'(cx), 320);
    chk("rst_cy", 32'(cy), 240);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ud", 32'(ud), 0);
    chk("rst_col", 32'(col), 0);
    chk("rst_cx3", 32'(cx3), 617);
    chk("rst_cy3", 32'(cy3), 21);
    speed = 3'd2;
    vs = 1'b0;
    cyc();
    chk("busy_e", 32'(busy), 1);
    cyc();
    cyc();
    chk("busy_e2", 32'(busy), 1);
    chk("hold_e2", 32'(cx), 320);
    cyc();
    chk("first_cx", 32'(cx), 322);
    chk("first_cy", 32'(cy), 242);
    chk("first_ud", 32'(ud), 1);
    chk("first_busy", 32'(busy), 0);
    vs = 1'b1;
    cyc();
    chk("ud_one_cycle", 32'(ud), 0);
    repeat (4) cyc();
    pause = 1'b1;
    u0 = ud_cnt;
    repeat (3) frame(2, 6);
    chk("pause_blocks", 32'(ud_cnt - u0), 0);
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    u0 = ud_cnt;
    frame(2, 6);
    chk("step_first_tick", 32'(ud_cnt - u0), 1);
    frame(2, 6);
    chk("step_only_once", 32'(ud_cnt - u0), 1);
    pause = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    vs = 1'b0;
    cyc();
    vs = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    u0 = ud_cnt;
    repeat (6) cyc();
    chk("abort_no_ud", 32'(ud_cnt - u0), 0);
    chk("abort_cx", 32'(cx), 320);
    chk("abort_cy", 32'(cy), 240);
    frame(4, 4);
    chk("fresh_cx", 32'(cx), 322);
    chk("fresh_cy", 32'(cy), 242);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    speed = 3'd3;
    u0 = ud3_cnt;
    for (int i = 1; i <= 6; i++) begin
      frame(2, 6);
      chk("div3_updates", 32'(ud3_cnt - u0), i / 3);
      if (i == 3) begin
        chk("clamp_x", 32'(cx3), 619);
        chk("down_y", 32'(cy3), 24);
        chk("bounce_col", 32'(col3), int'(CC));
      end
    end
    chk("reflect_x", 32'(cx3), 616);
    chk("down_y2", 32'(cy3), 27);
    chk("bounce_col2", 32'(col3), int'(CC));
    for (int i = 0; i < 700; i++) begin
      speed = 3'($urandom_range(0, 7));
      pause = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) begin
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      frame($urandom_range(1, 3), $urandom_range(1, 6));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
